// File: rtl/rr_mux2_stage.sv
// rr_mux2_stage: registered two-input round-robin arbitration stage.
// Requesters A and B compete for a single output register; when both are
// valid the one not granted last wins. Define RR_MUX2_STATS_EN to add
// per-input saturating grant counters with a synchronous clear.
//
// state | meaning
// EMPTY | output register holds no beat (z_valid=0)
// FULL  | output register holds a beat waiting for z_ready (z_valid=1)
module rr_mux2_stage #(
    parameter int SIZE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [SIZE-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [SIZE-1:0] b_data,
    output logic            b_ready,
    output logic            z_valid,
    output logic [SIZE-1:0] z_data,
    output logic            z_src,
    input  logic            z_ready
`ifdef RR_MUX2_STATS_EN
    ,
    input  logic            clr_cnt,
    output logic [7:0]      grant_cnt_a,
    output logic [7:0]      grant_cnt_b
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   last_q;
    logic   load_ok;
    logic   grant_vld;
    logic   grant_sel;

    assign z_valid = (state_q == FULL);

    // Grant decision, handshake readies and next state. Readies are held low
    // while rst is asserted so no handshake can complete during reset.
    always_comb begin
        state_d   = state_q;
        load_ok   = 1'b0;
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        load_ok   = !rst && ((state_q == EMPTY) || z_ready);
        if (load_ok) begin
            if (a_valid && b_valid) begin
                grant_vld = 1'b1;
                grant_sel = ~last_q;
            end else if (a_valid) begin
                grant_vld = 1'b1;
                grant_sel = 1'b0;
            end else if (b_valid) begin
                grant_vld = 1'b1;
                grant_sel = 1'b1;
            end
            a_ready = grant_vld && !grant_sel;
            b_ready = grant_vld && grant_sel;
            state_d = grant_vld ? FULL : EMPTY;
        end
    end

    // State, output register and round-robin pointer; data is only captured
    // on a grant so an unqualified input never reaches z_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            z_data  <= '0;
            z_src   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant_vld) begin
                z_data <= grant_sel ? b_data : a_data;
                z_src  <= grant_sel;
                last_q <= grant_sel;
            end
        end
    end

`ifdef RR_MUX2_STATS_EN
    // Saturating grant counters; clr_cnt wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            grant_cnt_a <= 8'd0;
            grant_cnt_b <= 8'd0;
        end else if (grant_vld) begin
            if (!grant_sel && (grant_cnt_a != 8'hFF))
                grant_cnt_a <= grant_cnt_a + 8'd1;
            if (grant_sel && (grant_cnt_b != 8'hFF))
                grant_cnt_b <= grant_cnt_b + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux2_stage.sv
// Testbench for rr_mux2_stage: a directed vector table followed by a
// randomized phase checked against a reference model and beat scoreboard.
module tb_rr_mux2_stage;

    logic       clk;
    logic       rst;
    logic       a_valid;
    logic [1:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [1:0] b_data;
    logic       b_ready;
    logic       z_valid;
    logic [1:0] z_data;
    logic       z_src;
    logic       z_ready;
`ifdef RR_MUX2_STATS_EN
    logic       clr_cnt;
    logic [7:0] grant_cnt_a;
    logic [7:0] grant_cnt_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rr_mux2_stage #(.SIZE(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .z_valid (z_valid),
        .z_data  (z_data),
        .z_src   (z_src),
        .z_ready (z_ready)
`ifdef RR_MUX2_STATS_EN
        ,
        .clr_cnt     (clr_cnt),
        .grant_cnt_a (grant_cnt_a),
        .grant_cnt_b (grant_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       av;
        logic [1:0] ad;
        logic       bv;
        logic [1:0] bd;
        logic       zr;
        logic       ear;
        logic       ebr;
        logic       ezv;
        logic [1:0] ezd;
        logic       ezs;
    } vec_t;

    typedef struct packed {
        logic [1:0] data;
        logic       src;
    } beat_t;

    vec_t  vq[$];
    beat_t sb[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bit    m_full;
        bit    m_last;
        bit    ga;
        bit    gb;
        bit    lo;
        beat_t bt;

        rst     = 1'b1;
        a_valid = 1'b0;
        a_data  = 2'b00;
        b_valid = 1'b0;
        b_data  = 2'b00;
        z_ready = 1'b0;
`ifdef RR_MUX2_STATS_EN
        clr_cnt = 1'b0;
`endif

        //            rst av ad     bv bd     zr  ar br  zv zd     zs
        vq.push_back('{1, 1, 2'b01, 1, 2'b11, 1,  0, 0,  0, 2'b00, 0}); // reset
        vq.push_back('{1, 1, 2'b01, 1, 2'b11, 1,  0, 0,  0, 2'b00, 0});
        vq.push_back('{0, 1, 2'b01, 1, 2'b11, 1,  1, 0,  1, 2'b01, 0}); // contention A
        vq.push_back('{0, 1, 2'b01, 1, 2'b11, 1,  0, 1,  1, 2'b11, 1}); // B
        vq.push_back('{0, 1, 2'b01, 1, 2'b11, 1,  1, 0,  1, 2'b01, 0}); // A
        vq.push_back('{0, 1, 2'b01, 1, 2'b11, 1,  0, 1,  1, 2'b11, 1}); // B
        vq.push_back('{0, 0, 2'b00, 0, 2'b00, 1,  0, 0,  0, 2'b11, 1}); // drain
        vq.push_back('{0, 1, 2'b10, 0, 2'b00, 1,  1, 0,  1, 2'b10, 0}); // single A
        vq.push_back('{0, 0, 2'b00, 1, 2'b11, 1,  0, 1,  1, 2'b11, 1}); // B refill
        vq.push_back('{0, 1, 2'b01, 0, 2'b00, 0,  0, 0,  1, 2'b11, 1}); // backpressure
        vq.push_back('{0, 1, 2'b01, 0, 2'b00, 0,  0, 0,  1, 2'b11, 1});
        vq.push_back('{0, 1, 2'b01, 0, 2'b00, 0,  0, 0,  1, 2'b11, 1});
        vq.push_back('{0, 1, 2'b01, 0, 2'b00, 1,  1, 0,  1, 2'b01, 0}); // drain+refill
        vq.push_back('{0, 0, 2'b00, 1, 2'b10, 0,  0, 0,  1, 2'b01, 0}); // full, stalled
        vq.push_back('{1, 1, 2'b01, 1, 2'b10, 0,  0, 0,  0, 2'b00, 0}); // reset mid-op
        vq.push_back('{0, 1, 2'b01, 1, 2'b10, 1,  1, 0,  1, 2'b01, 0}); // A first again
        vq.push_back('{0, 0, 2'bxx, 1, 2'b10, 1,  0, 1,  1, 2'b10, 1}); // X on idle A
        vq.push_back('{0, 0, 2'b00, 0, 2'b00, 0,  0, 0,  1, 2'b10, 1}); // hold
        vq.push_back('{0, 0, 2'b00, 0, 2'b00, 1,  0, 0,  0, 2'b10, 1}); // drain to empty

        foreach (vq[i]) begin
            @(negedge clk);
            rst     = vq[i].rst;
            a_valid = vq[i].av;
            a_data  = vq[i].ad;
            b_valid = vq[i].bv;
            b_data  = vq[i].bd;
            z_ready = vq[i].zr;
            #1;
            chk($sformatf("v%0d_a_ready", i), 8'(a_ready), 8'(vq[i].ear));
            chk($sformatf("v%0d_b_ready", i), 8'(b_ready), 8'(vq[i].ebr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_z_valid", i), 8'(z_valid), 8'(vq[i].ezv));
            chk($sformatf("v%0d_z_data", i),  8'(z_data),  8'(vq[i].ezd));
            chk($sformatf("v%0d_z_src", i),   8'(z_src),   8'(vq[i].ezs));
        end

        // Randomized traffic against a reference model and beat scoreboard.
        @(negedge clk);
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        m_full  = 1'b0;
        m_last  = 1'b1;
        ga      = 1'b0;
        gb      = 1'b0;
        sb.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst = 1'b0;
            if (!a_valid || ga) begin
                a_valid = 1'($urandom_range(0, 1));
                a_data  = 2'($urandom);
            end
            if (!b_valid || gb) begin
                b_valid = 1'($urandom_range(0, 1));
                b_data  = 2'($urandom);
            end
            z_ready = ($urandom_range(0, 3) != 0);
            #1;
            lo = !m_full || z_ready;
            ga = 1'b0;
            gb = 1'b0;
            if (lo) begin
                if (a_valid && b_valid) begin
                    if (m_last) ga = 1'b1;
                    else        gb = 1'b1;
                end else if (a_valid) begin
                    ga = 1'b1;
                end else if (b_valid) begin
                    gb = 1'b1;
                end
            end
            chk($sformatf("r%0d_a_ready", c), 8'(a_ready), 8'(ga));
            chk($sformatf("r%0d_b_ready", c), 8'(b_ready), 8'(gb));
            chk($sformatf("r%0d_z_valid", c), 8'(z_valid), 8'(m_full));
            if (m_full && z_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL r%0d_scoreboard: got beat expected none queued", c);
                end else begin
                    bt = sb.pop_front();
                    chk($sformatf("r%0d_z_data", c), 8'(z_data), 8'(bt.data));
                    chk($sformatf("r%0d_z_src", c),  8'(z_src),  8'(bt.src));
                end
            end
            if (ga) sb.push_back('{a_data, 1'b0});
            if (gb) sb.push_back('{b_data, 1'b1});
            if (ga || gb) begin
                m_full = 1'b1;
                m_last = gb;
            end else if (lo) begin
                m_full = 1'b0;
            end
        end
        chk("sb_residual", 8'(sb.size()), 8'(m_full));

`ifdef RR_MUX2_STATS_EN
        @(negedge clk);
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("cnt_a_reset", grant_cnt_a, 8'd0);
        chk("cnt_b_reset", grant_cnt_b, 8'd0);
        a_valid = 1'b1;
        a_data  = 2'b01;
        z_ready = 1'b1;
        repeat (300) @(negedge clk);
        chk("cnt_a_sat", grant_cnt_a, 8'd255);
        chk("cnt_b_sat", grant_cnt_b, 8'd0);
        a_valid = 1'b0;
        b_valid = 1'b1;
        @(negedge clk);
        chk("cnt_b_one", grant_cnt_b, 8'd1);
        a_valid = 1'b1;
        b_valid = 1'b0;
        clr_cnt = 1'b1;
        #1;
        chk("clr_grant_a_ready", 8'(a_ready), 8'd1);
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("cnt_a_clr", grant_cnt_a, 8'd0);
        chk("cnt_b_clr", grant_cnt_b, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux2_stage.md
Name: rr_mux2_stage

Overview:
- Registered two-input arbitration stage that feeds a 2-way select with a round-robin priority pointer and holds the selected beat in an output register.
- Two requesters (A, B) present SIZE-bit data with valid/ready handshakes.
- Chosen data is captured and presented downstream with valid/ready.
- Provides the sequential select control and output buffering that the combinational 2:1 mux datapath lacks.

Parameters:
SIZE, 2, data width of each input and of the output.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
a_valid  input  1  requester A has a beat
a_data  input  SIZE  requester A data
a_ready  output  1  A beat accepted this cycle (combinational)
b_valid  input  1  requester B has a beat
b_data  input  SIZE  requester B data
b_ready  output  1  B beat accepted this cycle (combinational)
z_valid  output  1  output register holds a beat
z_data  output  SIZE  held beat data
z_src  output  1  source of held beat: 0=A, 1=B
z_ready  input  1  downstream accepts held beat

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: z_valid=0, z_data=0, z_src=0, last=1 (internal pointer; A wins the first contention).
- FSM states:
  - EMPTY: z_valid=0.
  - FULL: z_valid=1.
- load_ok = EMPTY | (FULL & z_ready).
- Grant, evaluated combinationally when load_ok=1:
  - Only a_valid: grant A.
  - Only b_valid: grant B.
  - Both valid: grant the input opposite to last.
  - Neither valid: no grant.
- a_ready = load_ok & grant==A. b_ready = load_ok & grant==B. The two readies are never high together.
- On grant:
  - z_data <= selected data (mux select = grant).
  - z_src <= grant; last <= grant; next state FULL.
- load_ok with no grant: next state EMPTY if FULL & z_ready; EMPTY stays EMPTY.
- FULL & !z_ready: z_data, z_src and z_valid hold; both readies are 0; last unchanged.
- Latency: 1 cycle from an accepted input beat to z_valid. Throughput: 1 beat/cycle when z_ready is held at 1.
- Fairness: under continuous contention, grants alternate A,B,A,B. last updates only on an actual grant.
- Drain and refill in the same cycle: the old beat is consumed and the new beat is loaded; z_valid stays 1 with no bubble.
- Requester rules:
  - Must hold valid and data stable until ready.
  - valid must not depend on ready.
  - a_ready may depend on b_valid and b_ready may depend on a_valid, through contention.
- Reset mid-operation: the held beat is discarded and any in-progress handshake is void. The pointer returns to last=1.
- X on a data input whose valid=0 must not propagate to z_data.

Optional Feature:
- Macro: RR_MUX2_STATS_EN.
- Defined:
  - Adds output ports grant_cnt_a and grant_cnt_b, 8 bits each.
  - Each counts grants to its input and saturates at 255.
  - Both reset to 0 on rst.
  - A single port clr_cnt (input, 1) zeroes both counters synchronously. clr_cnt has priority over an increment in the same cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with a_valid=b_valid=1 -> z_valid=0, z_data=0, a_ready=b_ready=0. After release, the first grant is A.
- Single requester: a_valid=1, a_data=2'b10, z_ready=1 -> a_ready=1 that cycle; next cycle z_valid=1, z_data=2'b10, z_src=0.
- Contention: both valid for 4 cycles, a_data=2'b01, b_data=2'b11, z_ready=1 -> z_src sequence 0,1,0,1 and z_data 01,11,01,11 with no bubbles.
- Backpressure: FULL holding 2'b11 with z_ready=0 for 3 cycles and a_valid=1 -> z_data stable at 11, a_ready=0. When z_ready=1, A is loaded in the same cycle and z_valid stays 1.
- Reset mid-operation: FULL with z_ready=0, then rst=1 -> next cycle z_valid=0; the first post-reset grant under contention is A.
- RR_MUX2_STATS_EN: 300 consecutive A-only grants -> grant_cnt_a=255, grant_cnt_b=0. clr_cnt=1 together with a grant -> both counters read 0 the next cycle.
